// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, access kind and
// default word/address widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int WORD_W_DEF       = 32;
  localparam int MAX_D_STREAK_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    RESP
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle between the core (fetch + load/store), the arbiter and the RAM
// side, with one view per participant.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input logic clk,
  input logic rst
);

  logic              iren;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              dren;
  logic              dwen;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_store;
  logic [WORD_W-1:0] ram_load;
  logic              ram_ready;
  logic              busy;

  modport arbiter (
    input  clk, rst, iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, busy
  );

  modport datapath (
    input  clk, rst, ihit, iload, dhit, dload, busy,
    output iren, iaddr, dren, dwen, daddr, dstore
  );

  modport ram (
    input  clk, rst, ram_ren, ram_wen, ram_addr, ram_store,
    output ram_load, ram_ready
  );

  modport tb (
    input  clk, ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, busy,
    output rst, iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data accesses win, but a bounded data streak
// guarantees that a waiting instruction fetch eventually gets the port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int WORD_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              busy
);

  localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state, next_state;
  logic [STREAK_W-1:0] streak;
  logic [ADDR_W-1:0]   lat_addr;
  logic [WORD_W-1:0]   lat_store;
  mem_op_t             op;

  logic d_req;
  logic grant_d;
  logic grant_i;
  logic in_acc;
  logic keep;

  assign d_req  = dren | dwen;
  assign in_acc = (state == IACC) || (state == DACC);
  // A fetch survives only if the core still wants the same address when the
  // memory answers; a data access survives while any data request is held.
  assign keep   = (state == IACC) ? (iren && (iaddr == lat_addr)) : d_req;

  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !(iren && (streak == STREAK_MAX))) begin
          grant_d    = 1'b1;
          next_state = DACC;
        end else if (iren) begin
          grant_i    = 1'b1;
          next_state = IACC;
        end
      end
      IACC, DACC: if (ram_ready) next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak    <= '0;
      lat_addr  <= '0;
      lat_store <= '0;
      op        <= OP_READ;
    end else if (grant_d) begin
      lat_addr  <= daddr;
      lat_store <= dstore;
      op        <= dwen ? OP_WRITE : OP_READ;
      if (!iren)                     streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + 1'b1;
    end else if (grant_i) begin
      lat_addr <= iaddr;
      streak   <= '0;
    end
  end

  // Hit pulses and load words are registered so they appear during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ihit  <= 1'b0;
      dhit  <= 1'b0;
      iload <= '0;
      dload <= '0;
    end else begin
      ihit  <= 1'b0;
      dhit  <= 1'b0;
      iload <= '0;
      dload <= '0;
      if (in_acc && ram_ready && keep) begin
        if (state == IACC) begin
          ihit  <= 1'b1;
          iload <= ram_load;
        end else begin
          dhit  <= 1'b1;
          dload <= (op == OP_READ) ? ram_load : '0;
        end
      end
    end
  end

  assign ram_ren   = (state == IACC) || ((state == DACC) && (op == OP_READ));
  assign ram_wen   = (state == DACC) && (op == OP_WRITE);
  assign ram_addr  = lat_addr;
  assign ram_store = lat_store;
  assign busy      = (state != IDLE);

endmodule
